aq_gemac_arp_cache: RTL and testbench

Multi-entry ARP cache with automatic miss resolution, replacing the single peer-MAC slot between the UDP controller and the Layer 3 controller. It maps IPv4 addresses to MAC addresses over a parametrised number of entries, ages entries on an external tick, and picks an empty or oldest slot when it learns a new address. On a lookup miss it issues ARP requests, retries on timeout, and returns either the learned MAC or a failure.

---
 rtl/aq_gemac_arp_cache.sv | 197 +++++++++++++++++++
 tb/tb_aq_gemac_arp_cache.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_gemac_arp_cache.sv
// ARP cache: IPv4->MAC table with tick-based aging, oldest-entry replacement
// and an ARP request/retry engine that resolves lookup misses.
module aq_gemac_arp_cache #(
  parameter int ENTRIES   = 4,
  parameter int AGE_W     = 8,
  parameter int TIMEOUT_W = 16,
  parameter int ATTEMPTS  = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tick,
  input  logic                 i_flush,
  input  logic                 i_learn_valid,
  input  logic [31:0]          i_learn_ip,
  input  logic [47:0]          i_learn_mac,
  input  logic                 i_lookup_req,
  input  logic [31:0]          i_lookup_ip,
  output logic                 o_lookup_busy,
  output logic                 o_lookup_done,
  output logic                 o_lookup_hit,
  output logic [47:0]          o_lookup_mac,
  output logic                 o_arp_req,
  output logic [31:0]          o_arp_req_ip,
  input  logic                 i_arp_ack,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  output logic [4:0]           o_valid_count
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [3:0] ATT = ATTEMPTS[3:0];

  typedef enum logic [2:0] {S_IDLE, S_CMP, S_REQ, S_WAIT, S_DONE} state_t;

  logic [ENTRIES-1:0] r_valid;
  logic [31:0]        r_ip  [ENTRIES];
  logic [47:0]        r_mac [ENTRIES];
  logic [AGE_W-1:0]   r_age [ENTRIES];
  logic [4:0]         r_count;

  state_t             r_state;
  logic [31:0]        r_lk_ip;
  logic [3:0]         r_att;
  logic [TIMEOUT_W-1:0] r_timer;
  logic               r_busy, r_done, r_hit, r_arp_req;
  logic [47:0]        r_lk_mac;
  logic [31:0]        r_arp_ip;

  logic             w_lm_hit, w_free;
  logic [IDX_W-1:0] w_lm_idx, w_free_idx, w_old_idx, w_lrn_idx;
  logic [AGE_W-1:0] w_old_age;
  logic             w_cmp_hit;
  logic [47:0]      w_cmp_mac;
  logic [4:0]       w_pop;
  logic [TIMEOUT_W-1:0] w_tmo;
  logic             w_tmo_end, w_wait_hit;

  // Learn target: existing entry for this IP, else lowest free, else oldest
  always_comb begin
    w_lm_hit   = 1'b0;
    w_lm_idx   = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_cmp_hit  = 1'b0;
    w_cmp_mac  = '0;
    w_pop      = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_ip[i] == i_learn_ip)) begin
        w_lm_hit = 1'b1;
        w_lm_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_valid[i] && (r_ip[i] == r_lk_ip)) begin
        w_cmp_hit = 1'b1;
        w_cmp_mac = r_mac[i];
      end
      w_pop = w_pop + {4'd0, r_valid[i]};
    end
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int i = 1; i < ENTRIES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = IDX_W'(i);
      end
    end
    w_lrn_idx = w_lm_hit ? w_lm_idx : (w_free ? w_free_idx : w_old_idx);
  end

  assign w_tmo      = (i_timeout == '0) ? TIMEOUT_W'(1) : i_timeout;
  assign w_tmo_end  = (({1'b0, r_timer} + (TIMEOUT_W+1)'(1)) >= {1'b0, w_tmo});
  assign w_wait_hit = i_learn_valid && (i_learn_ip == r_lk_ip);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ip[i]  <= '0;
        r_mac[i] <= '0;
        r_age[i] <= '0;
      end
    end else begin
      r_count <= w_pop;
      for (int i = 0; i < ENTRIES; i++) begin
        if (i_flush) begin
          r_valid[i] <= 1'b0;
          r_age[i]   <= '0;
        end else if (i_learn_valid && (w_lrn_idx == IDX_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_ip[i]    <= i_learn_ip;
          r_mac[i]   <= i_learn_mac;
          r_age[i]   <= '0;
        end else if (i_tick && r_valid[i]) begin
          if (&r_age[i]) r_valid[i] <= 1'b0;
          else           r_age[i]   <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_lk_ip   <= '0;
      r_att     <= '0;
      r_timer   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hit     <= 1'b0;
      r_lk_mac  <= '0;
      r_arp_req <= 1'b0;
      r_arp_ip  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_lookup_req) begin
          r_lk_ip <= i_lookup_ip;
          r_att   <= '0;
          r_busy  <= 1'b1;
          r_state <= S_CMP;
        end
        S_CMP: if (w_cmp_hit) begin
          r_hit    <= 1'b1;
          r_lk_mac <= w_cmp_mac;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end else begin
          r_arp_req <= 1'b1;
          r_arp_ip  <= r_lk_ip;
          r_state   <= S_REQ;
        end
        S_REQ: if (i_arp_ack) begin
          r_arp_req <= 1'b0;
          r_att     <= r_att + 4'd1;
          r_timer   <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + TIMEOUT_W'(1);
          if (w_wait_hit) begin
            r_hit    <= 1'b1;
            r_lk_mac <= i_learn_mac;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_tmo_end) begin
            if (r_att < ATT) begin
              r_arp_req <= 1'b1;
              r_state   <= S_REQ;
            end else begin
              r_hit    <= 1'b0;
              r_lk_mac <= '0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lookup_busy = r_busy;
  assign o_lookup_done = r_done;
  assign o_lookup_hit  = r_hit;
  assign o_lookup_mac  = r_lk_mac;
  assign o_arp_req     = r_arp_req;
  assign o_arp_req_ip  = r_arp_ip;
  assign o_valid_count = r_count;

endmodule

// File: tb/tb_aq_gemac_arp_cache.sv
// Directed bench for aq_gemac_arp_cache: default instance plus an AGE_W=2
// instance sharing the same stimulus for the aging boundaries.
module tb_aq_gemac_arp_cache;

  logic        clk = 1'b0;
  logic        rst, tick, flush, lv, req, ack;
  logic [31:0] lip, lkip;
  logic [47:0] lmac;
  logic [15:0] tmo;

  logic        busy, done, hit, arq;
  logic [47:0] mac;
  logic [31:0] arq_ip;
  logic [4:0]  vcnt;
  logic        busy2, done2, hit2, arq2;
  logic [47:0] mac2;
  logic [31:0] arq_ip2;
  logic [4:0]  vcnt2;

  int errors = 0;
  int checks = 0;
  int cyc, pulses;

  always #5 clk = ~clk;

  aq_gemac_arp_cache u_dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_flush(flush),
    .i_learn_valid(lv), .i_learn_ip(lip), .i_learn_mac(lmac),
    .i_lookup_req(req), .i_lookup_ip(lkip),
    .o_lookup_busy(busy), .o_lookup_done(done), .o_lookup_hit(hit),
    .o_lookup_mac(mac), .o_arp_req(arq), .o_arp_req_ip(arq_ip),
    .i_arp_ack(ack), .i_timeout(tmo), .o_valid_count(vcnt)
  );

  aq_gemac_arp_cache #(.AGE_W(2)) u_dut_age2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_flush(flush),
    .i_learn_valid(lv), .i_learn_ip(lip), .i_learn_mac(lmac),
    .i_lookup_req(req), .i_lookup_ip(lkip),
    .o_lookup_busy(busy2), .o_lookup_done(done2), .o_lookup_hit(hit2),
    .o_lookup_mac(mac2), .o_arp_req(arq2), .o_arp_req_ip(arq_ip2),
    .i_arp_ack(ack), .i_timeout(tmo), .o_valid_count(vcnt2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] m);
    lv = 1'b1; lip = ip; lmac = m;
    step();
    lv = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic lookup_hit(input string tag, input logic [31:0] ip, input logic [47:0] m);
    req = 1'b1; lkip = ip;
    step();
    req = 1'b0;
    chk({tag, "_busy1"}, 64'(busy), 64'd1);
    chk({tag, "_done1"}, 64'(done), 64'd0);
    step();
    chk({tag, "_done2"}, 64'(done), 64'd1);
    chk({tag, "_hit"},   64'(hit),  64'd1);
    chk({tag, "_mac"},   64'(mac),  64'(m));
    chk({tag, "_noarp"}, 64'(arq),  64'd0);
    step();
    chk({tag, "_idle"},  64'(busy), 64'd0);
  endtask

  // Lookup with ACK held high; returns cycles from request to DONE and ARP_REQ pulse count
  task automatic lookup_miss(input logic [31:0] ip, output int c, output int p);
    logic prev;
    ack = 1'b1; req = 1'b1; lkip = ip;
    step();
    req = 1'b0;
    c = 1; p = 0; prev = 1'b0;
    while (c < 200) begin
      if (done) break;
      if (arq && !prev) p++;
      prev = arq;
      step();
      c++;
    end
    chk("miss_done_seen", 64'(done), 64'd1);
    chk("miss_hit",       64'(hit),  64'd0);
    chk("miss_mac",       64'(mac),  64'd0);
    ack = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; flush = 1'b0; lv = 1'b0; req = 1'b0; ack = 1'b0;
    lip = '0; lkip = '0; lmac = '0; tmo = 16'd10;
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hit",  64'(hit),  64'd0);
    chk("rst_mac",  64'(mac),  64'd0);
    chk("rst_arq",  64'(arq),  64'd0);
    chk("rst_arqip", 64'(arq_ip), 64'd0);
    chk("rst_vcnt", 64'(vcnt), 64'd0);
    chk("rst2_mac", 64'(mac2), 64'd0);
    chk("rst2_rest", 64'({busy2, done2, hit2, arq2, arq_ip2, vcnt2}), 64'd0);
    rst = 1'b0;
    step();

    // Learn then hit
    learn(32'hC0A8010A, 48'h001122334455);
    step();
    chk("learn_vcnt", 64'(vcnt), 64'd1);
    lookup_hit("hit1", 32'hC0A8010A, 48'h001122334455);

    // Full failure: 3 attempts, TIMEOUT=10 -> 35 cycles
    tmo = 16'd10;
    lookup_miss(32'h0A000001, cyc, pulses);
    chk("fail_cycles", 64'(cyc), 64'd35);
    chk("fail_pulses", 64'(pulses), 64'd3);

    // Miss resolved by a learn 4 cycles after the first ACK
    req = 1'b1; lkip = 32'h0A000002;
    step();
    req = 1'b0;
    step();
    chk("res_arq",   64'(arq),    64'd1);
    chk("res_arqip", 64'(arq_ip), 64'h0A000002);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("res_arq_drop", 64'(arq), 64'd0);
    chk("res_busy",     64'(busy), 64'd1);
    step(); step(); step();
    chk("res_not_done", 64'(done), 64'd0);
    learn(32'h0A000002, 48'hAABBCCDDEEFF);
    chk("res_done", 64'(done), 64'd1);
    chk("res_hit",  64'(hit),  64'd1);
    chk("res_mac",  64'(mac),  64'hAABBCCDDEEFF);
    step();
    lookup_hit("res_again", 32'h0A000002, 48'hAABBCCDDEEFF);

    // Eviction of the oldest entry
    pulse_flush();
    learn(32'h01000001, 48'h000000000001); pulse_tick();
    learn(32'h01000002, 48'h000000000002); pulse_tick();
    learn(32'h01000003, 48'h000000000003); pulse_tick();
    learn(32'h01000004, 48'h000000000004); pulse_tick();
    learn(32'h01000005, 48'h000000000005);
    step();
    chk("evict_vcnt", 64'(vcnt), 64'd4);
    lookup_hit("evict_new", 32'h01000005, 48'h000000000005);
    lookup_hit("evict_keep", 32'h01000002, 48'h000000000002);
    tmo = 16'd0;
    lookup_miss(32'h01000001, cyc, pulses);
    chk("evict_gone_cycles", 64'(cyc), 64'd8);
    chk("evict_gone_pulses", 64'(pulses), 64'd3);
    learn(32'h01000003, 48'h0000000000C3);
    step();
    chk("relearn_vcnt", 64'(vcnt), 64'd4);
    lookup_hit("relearn_mac", 32'h01000003, 48'h0000000000C3);
    lookup_hit("relearn_keep", 32'h01000004, 48'h000000000004);

    // AGE_W=2 aging
    pulse_flush();
    learn(32'h01020304, 48'h0000000000A1);
    step();
    chk("age_vcnt_init", 64'(vcnt2), 64'd1);
    pulse_tick(); pulse_tick(); pulse_tick();
    step();
    chk("age_vcnt_3", 64'(vcnt2), 64'd1);
    pulse_tick();
    step();
    chk("age_vcnt_4", 64'(vcnt2), 64'd0);
    chk("age_wide_kept", 64'(vcnt), 64'd1);

    pulse_flush();
    learn(32'h01020304, 48'h0000000000A1);
    pulse_tick(); pulse_tick(); pulse_tick();
    tick = 1'b1;
    learn(32'h01020304, 48'h0000000000A2);
    tick = 1'b0;
    step();
    chk("age_learn_win", 64'(vcnt2), 64'd1);
    pulse_tick(); pulse_tick(); pulse_tick();
    step();
    chk("age_reset_3", 64'(vcnt2), 64'd1);
    pulse_tick();
    step();
    chk("age_reset_4", 64'(vcnt2), 64'd0);

    // FLUSH beats a same-cycle learn
    pulse_flush();
    flush = 1'b1;
    learn(32'h05050505, 48'h000000000055);
    flush = 1'b0;
    step(); step();
    chk("flush_learn_vcnt",  64'(vcnt),  64'd0);
    chk("flush_learn_vcnt2", 64'(vcnt2), 64'd0);

    // Reset during WAIT
    tmo = 16'd10; ack = 1'b1; req = 1'b1; lkip = 32'h0A0000FF;
    step();
    req = 1'b0;
    step();
    chk("rstw_arq", 64'(arq), 64'd1);
    step();
    chk("rstw_wait_busy", 64'(busy), 64'd1);
    chk("rstw_wait_arq",  64'(arq),  64'd0);
    step();
    rst = 1'b1;
    #1;
    chk("rstw_arq0",  64'(arq),  64'd0);
    chk("rstw_busy0", 64'(busy), 64'd0);
    chk("rstw_done0", 64'(done), 64'd0);
    step();
    chk("rstw_nodone", 64'(done), 64'd0);
    rst = 1'b0; ack = 1'b0;
    step();
    chk("rstw_idle", 64'(busy), 64'd0);
    chk("rstw_nodone2", 64'(done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
